// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, word-addressed instruction memory with a
// program-load port, and the IF/ID pipeline register.

package if_stage_pkg;

    typedef struct packed {
        logic [31:0] next_pc;
        logic [31:0] instr;
    } if_id_t;

    typedef enum logic [2:0] {
        PC_LOAD,
        PC_BRANCH,
        PC_JUMP,
        PC_STALL,
        PC_HALT,
        PC_SEQ
    } pc_sel_e;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage

module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_load_en,
    input  logic [31:0] i_load_addr,
    input  logic [31:0] i_load_data,
    output logic [31:0] o_pc,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_instruction,
    output logic        o_halted
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic [31:0]   imem [IMEM_DEPTH];

    logic [31:0]   pc_q, pc_d;
    logic          halted_q, halted_d;
    if_id_t        ifid_q, ifid_d;

    pc_sel_e       pc_sel;
    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] load_idx;
    logic [31:0]   fetch_word;
    logic [31:0]   pc_plus4;

    logic          unused_addr_bits;

    assign fetch_idx  = pc_q[AW+1:2];
    assign load_idx   = i_load_addr[AW+1:2];
    assign fetch_word = imem[fetch_idx];
    assign pc_plus4   = pc_q + 32'd4;

    assign unused_addr_bits = ^{pc_q[31:AW+2], pc_q[1:0],
                                i_load_addr[31:AW+2], i_load_addr[1:0]};

    // Memory has no reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (!reset && i_load_en) begin
            imem[load_idx] <= i_load_data;
        end
    end

    // Resolve overlapping requests by age/priority before decoding.
    always_comb begin
        if (i_load_en) begin
            pc_sel = PC_LOAD;
        end else if (i_branch_taken) begin
            pc_sel = PC_BRANCH;
        end else if (i_jump) begin
            pc_sel = PC_JUMP;
        end else if (i_stall) begin
            pc_sel = PC_STALL;
        end else if (halted_q) begin
            pc_sel = PC_HALT;
        end else begin
            pc_sel = PC_SEQ;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        ifid_d   = ifid_q;

        unique case (pc_sel)
            PC_LOAD: begin
                pc_d     = RESET_PC;
                halted_d = 1'b0;
            end
            PC_BRANCH: begin
                pc_d     = i_branch_target;
                halted_d = 1'b0;
            end
            PC_JUMP: begin
                pc_d     = i_jump_target;
                halted_d = 1'b0;
            end
            PC_STALL: begin
                pc_d = pc_q;
            end
            PC_HALT: begin
                pc_d = pc_q;
            end
            PC_SEQ: begin
                pc_d = pc_plus4;
                if (!i_flush && fetch_word == HALT_WORD) begin
                    halted_d = 1'b1;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase

        if (pc_sel == PC_LOAD) begin
            ifid_d = '{next_pc: 32'd0, instr: NOP_WORD};
        end else if (i_flush) begin
            ifid_d = '{next_pc: 32'd0, instr: NOP_WORD};
        end else if (i_stall) begin
            ifid_d = ifid_q;
        end else if (halted_q) begin
            ifid_d = '{next_pc: 32'd0, instr: NOP_WORD};
        end else begin
            ifid_d = '{next_pc: pc_plus4, instr: fetch_word};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            ifid_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            ifid_q   <= ifid_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_next_pc     = ifid_q.next_pc;
    assign o_instruction = ifid_q.instr;
    assign o_halted      = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, redirects, halt, reset and
// program-load behaviour with hand-computed expectations.

module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_stall;
    logic        i_flush;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic        i_load_en;
    logic [31:0] i_load_addr;
    logic [31:0] i_load_data;
    logic [31:0] o_pc;
    logic [31:0] o_next_pc;
    logic [31:0] o_instruction;
    logic        o_halted;

    int compared = 0;
    int mismatched = 0;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    if_stage #(
        .IMEM_DEPTH(256),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_stall        (i_stall),
        .i_flush        (i_flush),
        .i_branch_taken (i_branch_taken),
        .i_branch_target(i_branch_target),
        .i_jump         (i_jump),
        .i_jump_target  (i_jump_target),
        .i_load_en      (i_load_en),
        .i_load_addr    (i_load_addr),
        .i_load_data    (i_load_data),
        .o_pc           (o_pc),
        .o_next_pc      (o_next_pc),
        .o_instruction  (o_instruction),
        .o_halted       (o_halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc,
                           input logic [31:0] npc, input logic [31:0] ins,
                           input logic hlt);
        chk({tag, ".pc"}, o_pc, pc);
        chk({tag, ".next_pc"}, o_next_pc, npc);
        chk({tag, ".instr"}, o_instruction, ins);
        chk({tag, ".halted"}, {31'd0, o_halted}, {31'd0, hlt});
    endtask

    initial begin
        reset = 1'b1;
        i_stall = 1'b0;
        i_flush = 1'b0;
        i_branch_taken = 1'b0;
        i_branch_target = '0;
        i_jump = 1'b0;
        i_jump_target = '0;
        i_load_en = 1'b0;
        i_load_addr = '0;
        i_load_data = '0;

        #2;
        step();
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);

        // Reset outranks load: no write happens.
        i_load_en = 1'b1;
        i_load_addr = 32'h0;
        i_load_data = HALT;
        step();
        reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            i_load_addr = i * 4;
            i_load_data = BASE + i;
            step();
        end
        i_load_en = 1'b0;
        chk_all("after_load", 32'h0, 32'h0, 32'h0, 1'b0);

        step();
        chk_all("seq0", 32'h4, 32'h4, BASE + 0, 1'b0);
        step();
        chk_all("seq1", 32'h8, 32'h8, BASE + 1, 1'b0);

        i_stall = 1'b1;
        step();
        chk_all("stall0", 32'h8, 32'h8, BASE + 1, 1'b0);
        step();
        chk_all("stall1", 32'h8, 32'h8, BASE + 1, 1'b0);
        i_stall = 1'b0;
        step();
        chk_all("seq2", 32'hC, 32'hC, BASE + 2, 1'b0);

        i_branch_taken = 1'b1;
        i_branch_target = 32'h40;
        i_flush = 1'b1;
        step();
        chk_all("br_flush", 32'h40, 32'h0, 32'h0, 1'b0);
        i_branch_taken = 1'b0;
        i_flush = 1'b0;
        step();
        chk_all("br_tgt", 32'h44, 32'h44, BASE + 16, 1'b0);

        i_branch_taken = 1'b1;
        i_branch_target = 32'h40;
        i_jump = 1'b1;
        i_jump_target = 32'h80;
        i_flush = 1'b1;
        step();
        chk("br_vs_jmp.pc", o_pc, 32'h40);
        i_branch_taken = 1'b0;
        step();
        chk("jmp.pc", o_pc, 32'h80);
        i_jump = 1'b0;
        i_flush = 1'b0;
        step();
        chk_all("jmp_tgt", 32'h84, 32'h84, BASE + 32, 1'b0);

        i_load_en = 1'b1;
        i_load_addr = 32'h8;
        i_load_data = HALT;
        step();
        i_load_en = 1'b0;
        chk_all("load_mid", 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk_all("h_seq0", 32'h4, 32'h4, BASE + 0, 1'b0);
        step();
        chk_all("h_seq1", 32'h8, 32'h8, BASE + 1, 1'b0);
        step();
        chk_all("halt_in", 32'hC, 32'hC, HALT, 1'b1);
        step();
        chk_all("halted", 32'hC, 32'h0, 32'h0, 1'b1);
        step();
        chk_all("halted2", 32'hC, 32'h0, 32'h0, 1'b1);

        i_branch_taken = 1'b1;
        i_branch_target = 32'h0;
        step();
        i_branch_taken = 1'b0;
        chk_all("unhalt", 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk_all("resume", 32'h4, 32'h4, BASE + 0, 1'b0);

        i_jump = 1'b1;
        i_jump_target = 32'h20;
        i_flush = 1'b1;
        step();
        i_jump = 1'b0;
        i_flush = 1'b0;
        chk("jmp20.pc", o_pc, 32'h20);
        step();
        chk_all("at24", 32'h24, 32'h24, BASE + 8, 1'b0);

        i_stall = 1'b1;
        reset = 1'b1;
        step();
        chk_all("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        i_stall = 1'b0;
        step();
        chk_all("rst_keep", 32'h4, 32'h4, BASE + 0, 1'b0);

        // Index wraps: 0x404 maps to word 1 in a 256-word memory.
        i_load_en = 1'b1;
        i_load_addr = 32'h404;
        i_load_data = 32'hDEAD_BEEF;
        step();
        i_load_en = 1'b0;
        chk_all("wrap_load", 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk_all("wrap0", 32'h4, 32'h4, BASE + 0, 1'b0);
        step();
        chk_all("wrap1", 32'h8, 32'h8, 32'hDEAD_BEEF, 1'b0);
        step();
        chk_all("wrap2", 32'hC, 32'hC, HALT, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
